// File: rtl/decode_pkg.sv
// Shared types for the decode stage: fetch/decode/execute bundles, RV64I opcodes,
// the decoded-operation enum and the immediate builders.
package decode_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  // OP_ILLEGAL sits at encoding 0 so a cleared ID/EX register reads as all-zero.
  typedef enum logic [5:0] {
    OP_ILLEGAL,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW
  } decode_op_t;

  typedef struct packed {
    u32    inst;
    addr_t pc;
  } if_id_t;

  typedef struct packed {
    addr_t      pc;
    u32         inst;
    decode_op_t op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    word_t      src1;
    word_t      src2;
    word_t      imm;
    logic       wen;
    logic       is_word;
    logic       illegal;
  } id_ex_t;

  function automatic word_t imm_i(input u32 inst);
    return {{52{inst[31]}}, inst[31:20]};
  endfunction

  function automatic word_t imm_s(input u32 inst);
    return {{52{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic word_t imm_b(input u32 inst);
    return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic word_t imm_u(input u32 inst);
    return {{32{inst[31]}}, inst[31:12], 12'b0};
  endfunction

  function automatic word_t imm_j(input u32 inst);
    return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode-stage bus: fetch-side handshake, register-file read port, flush and
// execute-side handshake. The stage itself connects through the slave modport.
interface decode_if;
  import decode_pkg::*;

  if_id_t     if_id_state;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] ra1;
  logic [4:0] ra2;
  word_t      rd1;
  word_t      rd2;
  logic       flush;
  id_ex_t     id_ex_state;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output if_id_state, in_valid, rd1, rd2, flush, out_ready,
    input  in_ready, ra1, ra2, id_ex_state, out_valid
  );

  modport slave (
    input  if_id_state, in_valid, rd1, rd2, flush, out_ready,
    output in_ready, ra1, ra2, id_ex_state, out_valid
  );

endinterface

// File: rtl/decode_decoder.sv
// Combinational RV64I decoder: classifies one instruction word and builds its
// immediate, destination/source fields and write-enable.
module decoder
  import decode_pkg::*;
(
  input  u32         inst,
  output decode_op_t op,
  output word_t      imm,
  output logic [4:0] rd,
  output logic [4:0] rs1,
  output logic [4:0] rs2,
  output logic       wen,
  output logic       is_word,
  output logic       illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  decode_op_t op_raw;
  word_t      imm_raw;
  logic       writes_rd;
  logic       word_op;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    op_raw    = OP_ILLEGAL;
    imm_raw   = '0;
    writes_rd = 1'b0;
    word_op   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op_raw = OP_LUI; imm_raw = imm_u(inst); writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op_raw = OP_AUIPC; imm_raw = imm_u(inst); writes_rd = 1'b1;
      end
      OPC_JAL: begin
        op_raw = OP_JAL; imm_raw = imm_j(inst); writes_rd = 1'b1;
      end
      OPC_JALR: begin
        imm_raw = imm_i(inst); writes_rd = 1'b1;
        if (funct3 == 3'b000) op_raw = OP_JALR;
      end
      OPC_BRANCH: begin
        imm_raw = imm_b(inst);
        case (funct3)
          3'b000:  op_raw = OP_BEQ;
          3'b001:  op_raw = OP_BNE;
          3'b100:  op_raw = OP_BLT;
          3'b101:  op_raw = OP_BGE;
          3'b110:  op_raw = OP_BLTU;
          3'b111:  op_raw = OP_BGEU;
          default: op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        imm_raw = imm_i(inst); writes_rd = 1'b1;
        case (funct3)
          3'b000:  op_raw = OP_LB;
          3'b001:  op_raw = OP_LH;
          3'b010:  op_raw = OP_LW;
          3'b011:  op_raw = OP_LD;
          3'b100:  op_raw = OP_LBU;
          3'b101:  op_raw = OP_LHU;
          3'b110:  op_raw = OP_LWU;
          default: op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        imm_raw = imm_s(inst);
        case (funct3)
          3'b000:  op_raw = OP_SB;
          3'b001:  op_raw = OP_SH;
          3'b010:  op_raw = OP_SW;
          3'b011:  op_raw = OP_SD;
          default: op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        imm_raw = imm_i(inst); writes_rd = 1'b1;
        // 64-bit shifts take a 6-bit shamt, leaving only inst[31:26] as funct6.
        case (funct3)
          3'b000: op_raw = OP_ADDI;
          3'b010: op_raw = OP_SLTI;
          3'b011: op_raw = OP_SLTIU;
          3'b100: op_raw = OP_XORI;
          3'b110: op_raw = OP_ORI;
          3'b111: op_raw = OP_ANDI;
          3'b001: begin
            imm_raw = {58'b0, inst[25:20]};
            if (inst[31:26] == 6'b000000) op_raw = OP_SLLI;
          end
          3'b101: begin
            imm_raw = {58'b0, inst[25:20]};
            if (inst[31:26] == 6'b000000)      op_raw = OP_SRLI;
            else if (inst[31:26] == 6'b010000) op_raw = OP_SRAI;
          end
          default: op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM32: begin
        imm_raw = imm_i(inst); writes_rd = 1'b1; word_op = 1'b1;
        case (funct3)
          3'b000: op_raw = OP_ADDIW;
          3'b001: begin
            imm_raw = {59'b0, inst[24:20]};
            if (funct7 == 7'b0000000) op_raw = OP_SLLIW;
          end
          3'b101: begin
            imm_raw = {59'b0, inst[24:20]};
            if (funct7 == 7'b0000000)      op_raw = OP_SRLIW;
            else if (funct7 == 7'b0100000) op_raw = OP_SRAIW;
          end
          default: op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: op_raw = OP_ADD;
          {7'h20, 3'd0}: op_raw = OP_SUB;
          {7'h00, 3'd1}: op_raw = OP_SLL;
          {7'h00, 3'd2}: op_raw = OP_SLT;
          {7'h00, 3'd3}: op_raw = OP_SLTU;
          {7'h00, 3'd4}: op_raw = OP_XOR;
          {7'h00, 3'd5}: op_raw = OP_SRL;
          {7'h20, 3'd5}: op_raw = OP_SRA;
          {7'h00, 3'd6}: op_raw = OP_OR;
          {7'h00, 3'd7}: op_raw = OP_AND;
          default:       op_raw = OP_ILLEGAL;
        endcase
      end
      OPC_OP32: begin
        writes_rd = 1'b1; word_op = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: op_raw = OP_ADDW;
          {7'h20, 3'd0}: op_raw = OP_SUBW;
          {7'h00, 3'd1}: op_raw = OP_SLLW;
          {7'h00, 3'd5}: op_raw = OP_SRLW;
          {7'h20, 3'd5}: op_raw = OP_SRAW;
          default:       op_raw = OP_ILLEGAL;
        endcase
      end
      default: op_raw = OP_ILLEGAL;
    endcase
  end

  // Illegal words carry a zero immediate and never write back.
  assign illegal = (op_raw == OP_ILLEGAL) || (inst[1:0] != 2'b11);
  assign op      = illegal ? OP_ILLEGAL : op_raw;
  assign imm     = illegal ? '0 : imm_raw;
  assign wen     = writes_rd && !illegal && (rd != 5'd0);
  assign is_word = word_op && !illegal;

endmodule

// File: rtl/decode.sv
// RV64I instruction decode stage: valid/ready handshake toward fetch and execute,
// register-file read addressing, and the ID/EX pipeline register.
module decode
  import decode_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  decode_op_t op_p0;
  word_t      imm_p0;
  logic [4:0] rd_p0;
  logic [4:0] rs1_p0;
  logic [4:0] rs2_p0;
  logic       wen_p0;
  logic       is_word_p0;
  logic       illegal_p0;
  id_ex_t     dec_p0;
  id_ex_t     id_ex_p1;
  logic       vld_p1;
  logic       accept;

  decoder u_decoder (
    .inst    (bus.if_id_state.inst),
    .op      (op_p0),
    .imm     (imm_p0),
    .rd      (rd_p0),
    .rs1     (rs1_p0),
    .rs2     (rs2_p0),
    .wen     (wen_p0),
    .is_word (is_word_p0),
    .illegal (illegal_p0)
  );

  assign bus.ra1 = bus.if_id_state.inst[19:15];
  assign bus.ra2 = bus.if_id_state.inst[24:20];

  // Flush does not gate in_ready: fetch sees its word as consumed and it is dropped here.
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    dec_p0         = '0;
    dec_p0.pc      = bus.if_id_state.pc;
    dec_p0.inst    = bus.if_id_state.inst;
    dec_p0.op      = op_p0;
    dec_p0.rd      = rd_p0;
    dec_p0.rs1     = rs1_p0;
    dec_p0.rs2     = rs2_p0;
    dec_p0.src1    = bus.rd1;
    dec_p0.src2    = bus.rd2;
    dec_p0.imm     = imm_p0;
    dec_p0.wen     = wen_p0;
    dec_p0.is_word = is_word_p0;
    dec_p0.illegal = illegal_p0;
  end

  // p0 -> p1: ID/EX register; fields only move on accept so a stall keeps them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      id_ex_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      id_ex_p1 <= dec_p0;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.id_ex_state = id_ex_p1;
  assign bus.out_valid   = vld_p1;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: table-driven reference decoder plus a transaction-level
// model of the ID/EX register, compared every cycle, with directed literal checks.
`timescale 1ns/1ps
module tb_decode;
  import decode_pkg::*;

  localparam int FU = 0, FJ = 1, FI = 2, FB = 3, FS = 4, FR = 5, FSH6 = 6, FSH5 = 7;

  typedef struct {
    logic [6:0] opc;
    int         f3;
    logic [6:0] f7;
    logic [6:0] f7m;
    decode_op_t op;
    int         fmt;
    bit         wr;
    bit         word;
  } enc_t;

  enc_t tbl[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;
  bit   exp_vld = 1'b0;
  id_ex_t exp_ie = '0;

  decode_if bus();
  decode u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [6:0] opc, input int f3, input logic [6:0] f7,
                              input logic [6:0] f7m, input decode_op_t op, input int fmt,
                              input bit wr, input bit word);
    enc_t e;
    e.opc = opc; e.f3 = f3; e.f7 = f7; e.f7m = f7m;
    e.op = op; e.fmt = fmt; e.wr = wr; e.word = word;
    tbl.push_back(e);
  endfunction

  // Every legal RV64I encoding: opcode, funct3 (-1 = any), funct7 value under mask.
  function automatic void fill_table();
    add(7'h37, -1, 7'h00, 7'h00, OP_LUI,   FU, 1, 0);
    add(7'h17, -1, 7'h00, 7'h00, OP_AUIPC, FU, 1, 0);
    add(7'h6F, -1, 7'h00, 7'h00, OP_JAL,   FJ, 1, 0);
    add(7'h67,  0, 7'h00, 7'h00, OP_JALR,  FI, 1, 0);
    add(7'h63,  0, 7'h00, 7'h00, OP_BEQ,  FB, 0, 0);
    add(7'h63,  1, 7'h00, 7'h00, OP_BNE,  FB, 0, 0);
    add(7'h63,  4, 7'h00, 7'h00, OP_BLT,  FB, 0, 0);
    add(7'h63,  5, 7'h00, 7'h00, OP_BGE,  FB, 0, 0);
    add(7'h63,  6, 7'h00, 7'h00, OP_BLTU, FB, 0, 0);
    add(7'h63,  7, 7'h00, 7'h00, OP_BGEU, FB, 0, 0);
    add(7'h03,  0, 7'h00, 7'h00, OP_LB,  FI, 1, 0);
    add(7'h03,  1, 7'h00, 7'h00, OP_LH,  FI, 1, 0);
    add(7'h03,  2, 7'h00, 7'h00, OP_LW,  FI, 1, 0);
    add(7'h03,  3, 7'h00, 7'h00, OP_LD,  FI, 1, 0);
    add(7'h03,  4, 7'h00, 7'h00, OP_LBU, FI, 1, 0);
    add(7'h03,  5, 7'h00, 7'h00, OP_LHU, FI, 1, 0);
    add(7'h03,  6, 7'h00, 7'h00, OP_LWU, FI, 1, 0);
    add(7'h23,  0, 7'h00, 7'h00, OP_SB, FS, 0, 0);
    add(7'h23,  1, 7'h00, 7'h00, OP_SH, FS, 0, 0);
    add(7'h23,  2, 7'h00, 7'h00, OP_SW, FS, 0, 0);
    add(7'h23,  3, 7'h00, 7'h00, OP_SD, FS, 0, 0);
    add(7'h13,  0, 7'h00, 7'h00, OP_ADDI,  FI, 1, 0);
    add(7'h13,  2, 7'h00, 7'h00, OP_SLTI,  FI, 1, 0);
    add(7'h13,  3, 7'h00, 7'h00, OP_SLTIU, FI, 1, 0);
    add(7'h13,  4, 7'h00, 7'h00, OP_XORI,  FI, 1, 0);
    add(7'h13,  6, 7'h00, 7'h00, OP_ORI,   FI, 1, 0);
    add(7'h13,  7, 7'h00, 7'h00, OP_ANDI,  FI, 1, 0);
    add(7'h13,  1, 7'h00, 7'h7E, OP_SLLI, FSH6, 1, 0);
    add(7'h13,  5, 7'h00, 7'h7E, OP_SRLI, FSH6, 1, 0);
    add(7'h13,  5, 7'h20, 7'h7E, OP_SRAI, FSH6, 1, 0);
    add(7'h1B,  0, 7'h00, 7'h00, OP_ADDIW, FI,   1, 1);
    add(7'h1B,  1, 7'h00, 7'h7F, OP_SLLIW, FSH5, 1, 1);
    add(7'h1B,  5, 7'h00, 7'h7F, OP_SRLIW, FSH5, 1, 1);
    add(7'h1B,  5, 7'h20, 7'h7F, OP_SRAIW, FSH5, 1, 1);
    add(7'h33,  0, 7'h00, 7'h7F, OP_ADD,  FR, 1, 0);
    add(7'h33,  0, 7'h20, 7'h7F, OP_SUB,  FR, 1, 0);
    add(7'h33,  1, 7'h00, 7'h7F, OP_SLL,  FR, 1, 0);
    add(7'h33,  2, 7'h00, 7'h7F, OP_SLT,  FR, 1, 0);
    add(7'h33,  3, 7'h00, 7'h7F, OP_SLTU, FR, 1, 0);
    add(7'h33,  4, 7'h00, 7'h7F, OP_XOR,  FR, 1, 0);
    add(7'h33,  5, 7'h00, 7'h7F, OP_SRL,  FR, 1, 0);
    add(7'h33,  5, 7'h20, 7'h7F, OP_SRA,  FR, 1, 0);
    add(7'h33,  6, 7'h00, 7'h7F, OP_OR,   FR, 1, 0);
    add(7'h33,  7, 7'h00, 7'h7F, OP_AND,  FR, 1, 0);
    add(7'h3B,  0, 7'h00, 7'h7F, OP_ADDW, FR, 1, 1);
    add(7'h3B,  0, 7'h20, 7'h7F, OP_SUBW, FR, 1, 1);
    add(7'h3B,  1, 7'h00, 7'h7F, OP_SLLW, FR, 1, 1);
    add(7'h3B,  5, 7'h00, 7'h7F, OP_SRLW, FR, 1, 1);
    add(7'h3B,  5, 7'h20, 7'h7F, OP_SRAW, FR, 1, 1);
  endfunction

  function automatic word_t imm_of(input u32 inst, input int fmt);
    case (fmt)
      FU:   return longint'($signed({inst[31:12], 12'b0}));
      FJ:   return longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FI:   return longint'($signed(inst[31:20]));
      FB:   return longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FS:   return longint'($signed({inst[31:25], inst[11:7]}));
      FSH6: return 64'(inst[25:20]);
      FSH5: return 64'(inst[24:20]);
      default: return 64'd0;
    endcase
  endfunction

  function automatic id_ex_t ref_decode(input u32 inst, input addr_t pc, input word_t s1, input word_t s2);
    id_ex_t r;
    int hit;
    hit = -1;
    r = '0;
    r.pc = pc; r.inst = inst; r.src1 = s1; r.src2 = s2;
    r.rd = inst[11:7]; r.rs1 = inst[19:15]; r.rs2 = inst[24:20];
    r.op = OP_ILLEGAL; r.illegal = 1'b1;
    foreach (tbl[k])
      if (hit < 0 && inst[6:0] == tbl[k].opc &&
          (tbl[k].f3 < 0 || inst[14:12] == tbl[k].f3[2:0]) &&
          ((inst[31:25] & tbl[k].f7m) == tbl[k].f7))
        hit = k;
    if (hit >= 0) begin
      r.op      = tbl[hit].op;
      r.illegal = 1'b0;
      r.imm     = imm_of(inst, tbl[hit].fmt);
      r.wen     = tbl[hit].wr && (inst[11:7] != 5'd0);
      r.is_word = tbl[hit].word;
    end
    return r;
  endfunction

  function automatic u32 rand_inst();
    u32 v;
    int k;
    v = $urandom();
    case ($urandom_range(0, 9))
      0: ;
      1: v[1:0] = 2'($urandom_range(0, 2));
      default: begin
        k = int'($urandom_range(0, tbl.size() - 1));
        v[6:0] = tbl[k].opc;
        if (tbl[k].f3 >= 0) v[14:12] = tbl[k].f3[2:0];
        v[31:25] = (v[31:25] & ~tbl[k].f7m) | tbl[k].f7;
      end
    endcase
    return v;
  endfunction

  // Transaction view of the stage: what is held, and whether it is live.
  always @(posedge clk) begin
    bit taken;
    bit consumed;
    if (rst) begin
      started = 1'b1;
      exp_vld = 1'b0;
      exp_ie  = '0;
    end else if (started) begin
      taken    = bus.in_valid && (!exp_vld || bus.out_ready) && !bus.flush;
      consumed = exp_vld && bus.out_ready;
      if (taken) exp_ie = ref_decode(bus.if_id_state.inst, bus.if_id_state.pc, bus.rd1, bus.rd2);
      exp_vld = taken || (exp_vld && !consumed && !bus.flush);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
      chk("in_ready", 64'(bus.in_ready), 64'(!exp_vld || bus.out_ready));
      chk("ra1", 64'(bus.ra1), 64'(bus.if_id_state.inst[19:15]));
      chk("ra2", 64'(bus.ra2), 64'(bus.if_id_state.inst[24:20]));
      n_cmp++;
      if (bus.id_ex_state !== exp_ie) begin
        n_bad++;
        $display("FAIL id_ex_state: got %h, expected %h", bus.id_ex_state, exp_ie);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input u32 inst, input word_t s1);
    bus.if_id_state.inst = inst;
    bus.if_id_state.pc   = {32'h0, $urandom()};
    bus.rd1      = s1;
    bus.rd2      = {$urandom(), $urandom()};
    bus.in_valid = 1'b1;
  endtask

  initial begin
    id_ex_t m;
    fill_table();
    bus.if_id_state = '0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.rd1 = '0; bus.rd2 = '0;

    m = ref_decode(32'h00500093, '0, '0, '0);
    chk("model.addi.imm", m.imm, 64'd5);
    chk("model.addi.op", 64'(m.op), 64'(OP_ADDI));
    m = ref_decode(32'h00208463, '0, '0, '0);
    chk("model.beq.imm", m.imm, 64'd8);
    chk("model.beq.wen", 64'(m.wen), 64'd0);
    m = ref_decode(32'h008000EF, '0, '0, '0);
    chk("model.jal.imm", m.imm, 64'd8);
    m = ref_decode(32'h4030D093, '0, '0, '0);
    chk("model.srai.op", 64'(m.op), 64'(OP_SRAI));
    chk("model.srai.imm", m.imm, 64'd3);

    tick(); tick();
    rst = 1'b0;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.fields", 64'(bus.id_ex_state == '0), 64'd1);

    bus.out_ready = 1'b0;
    drive(32'h00500093, 64'd0);
    tick();
    chk("addi.out_valid", 64'(bus.out_valid), 64'd1);
    chk("addi.op", 64'(bus.id_ex_state.op), 64'(OP_ADDI));
    chk("addi.rd", 64'(bus.id_ex_state.rd), 64'd1);
    chk("addi.imm", bus.id_ex_state.imm, 64'd5);
    chk("addi.wen", 64'(bus.id_ex_state.wen), 64'd1);
    chk("addi.src1", bus.id_ex_state.src1, 64'd0);

    drive(32'hFFF00193, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall.imm", bus.id_ex_state.imm, 64'd5);
      tick();
    end
    chk("stall.rd", 64'(bus.id_ex_state.rd), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("addim1.imm", bus.id_ex_state.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addim1.rd", 64'(bus.id_ex_state.rd), 64'd3);
    chk("addim1.out_valid", 64'(bus.out_valid), 64'd1);

    drive(32'h12345137, 64'd0);
    tick();
    chk("lui.imm", bus.id_ex_state.imm, 64'h0000_0000_1234_5000);
    chk("lui.op", 64'(bus.id_ex_state.op), 64'(OP_LUI));

    drive(32'h00700213, 64'd0);
    bus.flush = 1'b1;
    chk("flush.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("flush.dropped", 64'(bus.out_valid), 64'd0);

    drive(32'h00000000, 64'd0);
    tick();
    chk("zero.illegal", 64'(bus.id_ex_state.illegal), 64'd1);
    chk("zero.op", 64'(bus.id_ex_state.op), 64'(OP_ILLEGAL));
    chk("zero.wen", 64'(bus.id_ex_state.wen), 64'd0);
    chk("zero.out_valid", 64'(bus.out_valid), 64'd1);

    drive(32'h00100013, 64'd0);
    tick();
    chk("addix0.op", 64'(bus.id_ex_state.op), 64'(OP_ADDI));
    chk("addix0.wen", 64'(bus.id_ex_state.wen), 64'd0);

    bus.out_ready = 1'b0;
    drive(32'h00500093, 64'd7);
    tick();
    chk("rststall.held", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rststall.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rststall.fields", 64'(bus.id_ex_state == '0), 64'd1);
    chk("rststall.in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.if_id_state.inst = rand_inst();
      bus.if_id_state.pc   = {$urandom(), $urandom()};
      bus.rd1 = {$urandom(), $urandom()};
      bus.rd2 = {$urandom(), $urandom()};
      tick();
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
